lut_v_loader: RTL and testbench

- Writable replacement for the V lookup table used by the AV1 arithmetic encoder.
- Accepts the table contents as a valid/ready word stream, writes them into internal storage in ascending address order, then checks a trailing checksum word.
- Once the checksum passes, it serves combinational reads to the encoder, with the same addr->q behaviour as the read-only table.
- This is the writer end of the table: contents are loaded at run time instead of from a memory-init file.

---
 rtl/lut_v_loader.sv | 104 ++++++++++
 tb/tb_lut_v_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lut_v_loader.sv
// Run-time loadable V lookup table for the AV1 arithmetic encoder.
// Streams in 2**ADDR_WIDTH words plus a checksum, then serves combinational reads.
module lut_v_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  lut_ready,
  output logic                  load_error,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CSUM  = 3'd2,
    READY = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic                  xfer;

  // Modulo-2**DATA_WIDTH accumulation; the carry out is intentionally dropped.
  function automatic logic [DATA_WIDTH-1:0] csum_add(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] full;
    full = {1'b0, a} + {1'b0, b};
    return full[DATA_WIDTH-1:0];
  endfunction

  assign xfer = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sum        <= '0;
      lut_ready  <= 1'b0;
      load_error <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      case (state)
        IDLE, READY, ERROR: begin
          if (load_start) begin
            state      <= LOAD;
            cnt        <= '0;
            sum        <= '0;
            lut_ready  <= 1'b0;
            load_error <= 1'b0;
            busy       <= 1'b1;
            in_ready   <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer) begin
            sum <= csum_add(sum, in_data);
            cnt <= cnt + ADDR_WIDTH'(1);
            if (&cnt) state <= CSUM;
          end
        end
        CSUM: begin
          if (xfer) begin
            busy     <= 1'b0;
            in_ready <= 1'b0;
            if (in_data == sum) begin
              state     <= READY;
              lut_ready <= 1'b1;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          lut_ready  <= 1'b0;
          load_error <= 1'b0;
          busy       <= 1'b0;
          in_ready   <= 1'b0;
        end
      endcase
    end
  end

  // Table storage is data only: no reset, validity is tracked by lut_ready.
  always_ff @(posedge clk) begin
    if (state == LOAD && xfer) mem[cnt] <= in_data;
  end

  assign q = lut_ready ? mem[addr] : '0;

endmodule

// File: tb/tb_lut_v_loader.sv
// Randomized directed bench for lut_v_loader: a small (4-word) and a full (256-word) table.
module tb_lut_v_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ls [2];
  logic        iv [2];
  logic [15:0] id [2];
  logic        ir [2];
  logic        lr [2];
  logic        le [2];
  logic        bz [2];
  logic [15:0] qq [2];
  logic [1:0]  addr_s;
  logic [7:0]  addr_b;

  int n_chk  = 0;
  int n_fail = 0;
  int xfers  = 0;

  // Reference contents of each table, as the bench intends them to be loaded.
  logic [15:0] mdl [2][256];

  always #5 clk = ~clk;

  lut_v_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) u_small (
    .clk(clk), .rst_n(rst_n), .load_start(ls[0]), .in_valid(iv[0]), .in_data(id[0]),
    .in_ready(ir[0]), .addr(addr_s), .q(qq[0]), .lut_ready(lr[0]), .load_error(le[0]),
    .busy(bz[0])
  );

  lut_v_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) u_big (
    .clk(clk), .rst_n(rst_n), .load_start(ls[1]), .in_valid(iv[1]), .in_data(id[1]),
    .in_ready(ir[1]), .addr(addr_b), .q(qq[1]), .lut_ready(lr[1]), .load_error(le[1]),
    .busy(bz[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int depth(input int sel);
    return (sel == 0) ? 4 : 256;
  endfunction

  task automatic rd(input int sel, input int a, input logic [15:0] exp, input string tag);
    if (sel == 0) addr_s = 2'(a);
    else          addr_b = 8'(a);
    #1;
    chk(tag, {16'h0, qq[sel]}, {16'h0, exp});
  endtask

  task automatic pulse_start(input int sel);
    ls[sel] = 1'b1;
    step();
    ls[sel] = 1'b0;
    chk("start_busy", {31'h0, bz[sel]}, 32'h1);
    chk("start_lut_ready_low", {31'h0, lr[sel]}, 32'h0);
    chk("start_error_low", {31'h0, le[sel]}, 32'h0);
  endtask

  // Offer one word, optionally after idle gaps, and wait (bounded) for it to transfer.
  task automatic send_word(input int sel, input logic [15:0] w, input int gaps);
    int k;
    iv[sel] = 1'b0;
    for (int g = 0; g < gaps; g++) begin
      step();
      if (g == 0) begin
        chk("stall_busy", {31'h0, bz[sel]}, 32'h1);
        chk("stall_not_ready", {31'h0, lr[sel]}, 32'h0);
      end
    end
    iv[sel] = 1'b1;
    id[sel] = w;
    k = 0;
    while (ir[sel] !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    if (ir[sel] !== 1'b1) chk("in_ready_timeout", {31'h0, ir[sel]}, 32'h1);
    step();
    xfers++;
    iv[sel] = 1'b0;
  endtask

  task automatic load(input int sel, input logic [15:0] csum_delta, input int maxgap);
    logic [15:0] s;
    s = 16'h0;
    pulse_start(sel);
    for (int i = 0; i < depth(sel); i++) begin
      s = s + mdl[sel][i];
      send_word(sel, mdl[sel][i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    end
    send_word(sel, s + csum_delta, 0);
  endtask

  task automatic check_ready(input int sel, input string tag);
    chk({tag, "_lut_ready"}, {31'h0, lr[sel]}, 32'h1);
    chk({tag, "_error"}, {31'h0, le[sel]}, 32'h0);
    chk({tag, "_busy"}, {31'h0, bz[sel]}, 32'h0);
    chk({tag, "_in_ready"}, {31'h0, ir[sel]}, 32'h0);
    for (int a = 0; a < depth(sel); a++) rd(sel, a, mdl[sel][a], {tag, "_read"});
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      ls[s] = 1'b0; iv[s] = 1'b0; id[s] = 16'h0;
    end
    addr_s = 2'd0;
    addr_b = 8'd0;

    // Asynchronous reset asserted mid-cycle.
    step();
    #2 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_lut_ready", {31'h0, lr[s]}, 32'h0);
      chk("rst_load_error", {31'h0, le[s]}, 32'h0);
      chk("rst_in_ready", {31'h0, ir[s]}, 32'h0);
      chk("rst_busy", {31'h0, bz[s]}, 32'h0);
      chk("rst_q", {16'h0, qq[s]}, 32'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) step();
    chk("idle_busy", {31'h0, bz[0]}, 32'h0);
    chk("idle_in_ready", {31'h0, ir[0]}, 32'h0);
    for (int a = 0; a < 4; a++) rd(0, a, 16'h0, "idle_q");

    // Good load on the 4-word table.
    mdl[0][0] = 16'h0001; mdl[0][1] = 16'h0010; mdl[0][2] = 16'h0100; mdl[0][3] = 16'h1000;
    xfers = 0;
    load(0, 16'h0, 0);
    chk("good_xfers", xfers, 5);
    check_ready(0, "good");
    rd(0, 2, 16'h0100, "good_addr2");
    rd(0, 3, 16'h1000, "good_addr3");

    // Same data with a checksum one off.
    load(0, 16'h1, 0);
    chk("bad_error", {31'h0, le[0]}, 32'h1);
    chk("bad_lut_ready", {31'h0, lr[0]}, 32'h0);
    chk("bad_busy", {31'h0, bz[0]}, 32'h0);
    for (int a = 0; a < 4; a++) rd(0, a, 16'h0, "bad_q");

    // Full table of 0xFFFF with random stalls; checksum wraps.
    for (int i = 0; i < 256; i++) mdl[1][i] = 16'hFFFF;
    load(1, 16'h0, 2);
    check_ready(1, "ovf");

    // Reload from READY: start arrives together with a bogus valid word.
    for (int i = 0; i < 256; i++) mdl[1][i] = 16'($urandom);
    iv[1] = 1'b1;
    id[1] = 16'hDEAD;
    pulse_start(1);
    iv[1] = 1'b0;
    chk("reload_in_ready", {31'h0, ir[1]}, 32'h1);
    begin
      logic [15:0] s;
      s = 16'h0;
      for (int i = 0; i < 256; i++) begin
        if (i == 100) begin
          ls[1] = 1'b1;
          step();
          ls[1] = 1'b0;
          chk("ignored_start_busy", {31'h0, bz[1]}, 32'h1);
          chk("ignored_start_in_ready", {31'h0, ir[1]}, 32'h1);
        end
        s = s + mdl[1][i];
        send_word(1, mdl[1][i], int'($urandom_range(1, 0)));
      end
      send_word(1, s, 0);
    end
    check_ready(1, "reload");

    // Reset after two of four words, then a fresh load.
    for (int i = 0; i < 4; i++) mdl[0][i] = 16'($urandom);
    pulse_start(0);
    send_word(0, mdl[0][0], 0);
    send_word(0, mdl[0][1], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'h0, bz[0]}, 32'h0);
    chk("midrst_lut_ready", {31'h0, lr[0]}, 32'h0);
    chk("midrst_in_ready", {31'h0, ir[0]}, 32'h0);
    chk("midrst_big_lut_ready", {31'h0, lr[1]}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) step();
    chk("midrst_stays_idle", {31'h0, bz[0]}, 32'h0);
    rd(0, 0, 16'h0, "midrst_q");
    load(0, 16'h0, 1);
    check_ready(0, "fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
